// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and response record.
package apb_pkg;

  localparam int BYTE_WIDTH         = 8;
  localparam int APB_MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  // Response record as seen by the requester; rdata sized for the widest bus.
  typedef struct packed {
    logic [APB_MAX_DATA_WIDTH-1:0] rdata;
    logic                          err;
    logic                          timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles spent waiting on PREADY; flags the last allowed cycle.
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;

  // Wait-cycle counter: cleared per transfer, advances on each PREADY-low ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (en && TIMEOUT_CYCLES > 0)  cnt <= cnt + CW'(1);
  end

  // expire marks the TIMEOUT_CYCLES-th waiting cycle; the FSM aborts only if PREADY is still low.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      assign expire = (cnt == LAST);
    end else begin : g_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command/response front end driving a single APB4 slave segment.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic                             cmd_write,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] cmd_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);
  localparam int SW = DATA_WIDTH / BYTE_WIDTH;

  apb_mst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;
  logic [SW-1:0]           pstrb_d;
  logic                    rsp_valid_d, err_d, to_d;
  logic                    ctr_clr, ctr_en, ctr_expire;

  // Ready is a pure state decode, held low while reset is asserted.
  assign cmd_ready = (state_q == IDLE) && PRESETn;

  apb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expire (ctr_expire)
  );

  // State and all APB/response outputs are registered; reset drops them asynchronously.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      PADDR       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      PADDR       <= paddr_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rdata_d;
      rsp_err     <= err_d;
      rsp_timeout <= to_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a state says otherwise.
  always_comb begin
    state_d     = state_q;
    paddr_d     = PADDR;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
    rsp_valid_d = rsp_valid;
    rdata_d     = rsp_rdata;
    err_d       = rsp_err;
    to_d        = rsp_timeout;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          // Reads carry no data or strobes onto the bus.
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          ctr_clr   = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completing PREADY wins over an expiring timeout in the same cycle.
        if (PREADY) begin
          rdata_d     = PWRITE ? '0 : PRDATA;
          err_d       = PSLVERR;
          to_d        = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          ctr_en = 1'b1;
          if (ctr_expire) begin
            rdata_d     = '0;
            err_d       = 1'b1;
            to_d        = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          to_d        = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple valid/ready command/response interface into APB4 master transfers. It drives the APB slave memory (PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB) and returns PRDATA/PSLVERR to the requester. It sits directly upstream of the APB slave and is the only APB master on that segment. It supports slave wait states and adds a bounded-wait timeout.

Parameters:
ADDR_WIDTH, 32, command/APB address width
DATA_WIDTH, 32, data width; must be a multiple of 8
TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before abort; 0 disables timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge accepts command
cmd_addr  in  ADDR_WIDTH  target address, passed to PADDR unmodified
cmd_write  in  1  1=write, 0=read
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset is asynchronous and active-low on PRESETn, clocked on PCLK. Every output resets to 0. State resets to IDLE and the timeout counter resets to 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered.
- IDLE:
  - cmd_ready=1 (decoded from the state register). All other states: cmd_ready=0.
  - On cmd_valid&cmd_ready: latch the command into PADDR/PWRITE/PWDATA/PSTRB. PSTRB is forced to 0 on reads and PWDATA is held at 0 on reads.
  - Set PSEL=1, PENABLE=0, go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS.
- ACCESS:
  - PADDR/PWRITE/PWDATA/PSTRB stay stable.
  - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err=PSLVERR, rsp_timeout=0. Clear PSEL and PENABLE, set rsp_valid=1, go to RESP.
  - Else: increment the counter.
- Timeout (TIMEOUT_CYCLES>0): when the counter reaches TIMEOUT_CYCLES with PREADY still 0:
  - Clear PSEL/PENABLE.
  - Set rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Go to RESP.
  - PREADY=1 in the same cycle takes priority over timeout.
  - The counter clears on entry to SETUP.
- RESP: rsp_valid=1 and rsp_* are held stable until rsp_ready=1, then go to IDLE, clearing rsp_valid and the rsp_* fields.
- Latency with a zero-wait slave:
  - Cmd accepted at edge N.
  - PSEL=1 during cycle N+1.
  - PENABLE=1 during cycle N+2.
  - rsp_valid=1 during cycle N+3.
  - Each PREADY-low cycle adds 1.
  - Peak throughput is 1 transfer per 4 cycles with rsp_ready tied high.
- After a transfer, PADDR/PWRITE/PWDATA/PSTRB keep their last values while PSEL=0. PENABLE is never 1 while PSEL=0.
- Only one outstanding transfer at a time. No new command is accepted while the response is backpressured.
- Reset asserted mid-transfer:
  - PSEL/PENABLE drop immediately (asynchronously).
  - The pending response is discarded.
  - After release the bridge restarts in IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - localparam BYTE_WIDTH=8;
  - struct apb_rsp_t {rdata, err, timeout}.
- Optional sub-module apb_timeout_ctr: clear/enable/expire counter parameterised by TIMEOUT_CYCLES. Everything else stays in one module.

Test Plan:
- Write addr 0x5, wdata 0xA5A55A5A, strb 0xF, zero-wait slave -> PSEL high at N+1, PENABLE at N+2, rsp_valid at N+3 with err=0, rdata=0. A follow-up read of 0x5 returns rsp_rdata=0xA5A55A5A.
- Partial write strb 0x2, wdata 0x0000FF00, to a word holding 0xA5A55A5A -> readback 0xA5A5FF5A. A read command with strb 0xF drives PSTRB=0.
- Read addr 0x100 on a 256-deep slave -> rsp_err=1, rsp_rdata=0xFFFFFFFF, rsp_timeout=0.
- Slave holds PREADY low 3 cycles -> ACCESS lasts 4 cycles with PADDR/PWDATA/PSEL/PENABLE stable. rsp_valid arrives at N+6.
- PREADY stuck low, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. The next command then completes normally.
- Backpressure and reset:
  - rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, a concurrent cmd_valid is not accepted.
  - PRESETn low mid-ACCESS -> PSEL/PENABLE/rsp_valid are 0 immediately, and cmd_ready=1 on the first cycle after release.
